// File: rtl/mdu_hazard_ctrl.sv
// mdu_hazard_ctrl
// E-stage issue and hazard controller for the multiply/divide unit.
// The block holds the MD op that leaves D and presents it to the MDU as
// MDUControl/Start. A 4-bit shadow countdown mirrors the MDU latency, so
// Stall can keep any MD-class op out of E while the unit is occupied.
// The block also produces the HI/LO read select for mfhi/mflo in E.
// Mismatch is a sticky flag. It is set when the MDU Busy output and the
// shadow count disagree, or when a Start reaches the MDU while it is busy.
// StallCount is a free-running count of stalled cycles.
module mdu_hazard_ctrl #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  D_MDOp,
   input  logic        Stall_other,
   input  logic        Busy,
   output logic [3:0]  E_MDUControl,
   output logic        E_Start,
   output logic [1:0]  E_HiLoSel,
   output logic        Stall,
   output logic        Mismatch,
   output logic [31:0] StallCount
);

   // MD op encoding shared with the MDU
   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_FDIV  = 4'd9;

   // Shadow-count load values. Both latencies must fit in the 4-bit counter.
   localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

   // Codes above fdiv are not instructions and behave as a nop.
   function automatic logic [3:0] legal_op(input logic [3:0] op);
      logic [3:0] r;
      r = (op > OP_FDIV) ? OP_NONE : op;
      return r;
   endfunction

   // Ops that start a multi-cycle MDU operation.
   function automatic logic is_start_op(input logic [3:0] op);
      logic r;
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_FDIV: r = 1'b1;
         default:                                     r = 1'b0;
      endcase
      return r;
   endfunction

   // Ops that read or write HI/LO directly.
   function automatic logic is_access_op(input logic [3:0] op);
      logic r;
      case (op)
         OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   // Busy latency of a start-class op. Multiplies are short. Everything
   // else in the class is divide-like.
   function automatic logic [3:0] lat_of(input logic [3:0] op);
      logic [3:0] r;
      case (op)
         OP_MULT, OP_MULTU: r = MULT_CNT;
         default:           r = DIV_CNT;
      endcase
      return r;
   endfunction

   logic [3:0]  e_op_q, e_op_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        mismatch_q, mismatch_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic [3:0]  d_op;
   logic        d_is_md;
   logic        e_start;
   logic        cnt_busy;
   logic        stall;

   // Decode D and E, then form the stall request
   always_comb begin
      d_op     = legal_op(D_MDOp);
      d_is_md  = is_start_op(d_op) | is_access_op(d_op);
      e_start  = is_start_op(e_op_q);
      cnt_busy = (cnt_q != 4'd0);
      // The op in E has not issued yet and still counts as occupancy.
      // Busy is ORed in so that a late MDU also holds the pipe.
      stall    = d_is_md & (e_start | cnt_busy | Busy);
   end

   // Next-state for the E register, the shadow counter, Mismatch and the stall counter
   always_comb begin
      e_op_d      = e_op_q;
      cnt_d       = cnt_q;
      mismatch_d  = mismatch_q;
      stall_cnt_d = stall_cnt_q;

      // A local stall or an external one turns E into a bubble. In both
      // cases the op stays in D and is presented again.
      if (stall || Stall_other) begin
         e_op_d = OP_NONE;
      end else begin
         e_op_d = d_op;
      end

      // A Start that arrives while the count is running is never loaded.
      // It is flagged through Mismatch below.
      if (e_start && !cnt_busy) begin
         cnt_d = lat_of(e_op_q);
      end else if (cnt_busy) begin
         cnt_d = cnt_q - 4'd1;
      end

      // Compare against the count before this edge's update.
      if ((Busy != cnt_busy) || (e_start && cnt_busy)) begin
         mismatch_d = 1'b1;
      end

      if (stall) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // State registers. Reset clears the count together with the MDU, so no
   // Mismatch can be raised on a reset edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_op_q      <= OP_NONE;
         cnt_q       <= 4'd0;
         mismatch_q  <= 1'b0;
         stall_cnt_q <= 32'd0;
      end else begin
         e_op_q      <= e_op_d;
         cnt_q       <= cnt_d;
         mismatch_q  <= mismatch_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Output drive
   always_comb begin
      E_MDUControl = e_op_q;
      E_Start      = e_start;
      Stall        = stall;
      Mismatch     = mismatch_q;
      StallCount   = stall_cnt_q;
      E_HiLoSel    = 2'b00;
      if (e_op_q == OP_MFHI) begin
         E_HiLoSel = 2'b01;
      end else if (e_op_q == OP_MFLO) begin
         E_HiLoSel = 2'b10;
      end
   end

endmodule

// File: doc/mdu_hazard_ctrl.md
# mdu_hazard_ctrl

E-stage issue and hazard controller for the multiply/divide unit (MDU) in the P6 five-stage pipeline. It latches the MD operation leaving the D stage and drives the MDU's MDUControl and Start inputs from it. It tracks MDU occupancy with a shadow countdown that mirrors the MDU's latency and raises Stall so that no MD-class instruction reaches the MDU while it is busy. It also produces the HI/LO read select for mfhi/mflo in E and checks the MDU Busy output against the shadow count.

## Interface

- MULT_LAT, 5, cycles of Busy after a mult/multu issue edge
- DIV_LAT, 10, cycles of Busy after a div/divu/fdiv issue edge
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- D_MDOp  input  4  MD op of the instruction in D: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 fdiv; codes 10–15 are treated as 0
- Stall_other  input  1  stall from the rest of the hazard unit (e.g. load-use); inserts a bubble into E
- Busy  input  1  MDU Busy output
- E_MDUControl  output  4  registered E-stage MD op, wired to MDU MDUControl
- E_Start  output  1  high when E_MDUControl is in {1,2,3,4,9}
- E_HiLoSel  output  2  01 when E op is mfhi, 10 when mflo, 00 otherwise
- Stall  output  1  freeze F/D and bubble E
- Mismatch  output  1  sticky: Busy disagreed with the shadow count
- StallCount  output  32  cycles in which Stall was high (wraps)

## Operation

- Start class: {1,2,3,4,9}. Access class: {5,6,7,8}. MD class: Start class plus access class.
- Stall (combinational) = D op in MD class AND (E_Start OR cnt != 0 OR Busy).
- E register update on each edge:
  - reset: loaded with 0.
  - Stall or Stall_other: loaded with 0 (bubble).
  - otherwise: loaded with D_MDOp, with illegal codes mapped to 0.
- Shadow counter cnt (4 bits), updated each edge, in priority order:
  - reset: cnt=0.
  - E_Start and cnt==0: cnt = MULT_LAT for ops 1/2, DIV_LAT for ops 3/4/9.
  - cnt != 0: cnt decrements by 1.
  - otherwise: cnt holds.
- An E_Start while cnt != 0 must not occur (the Stall rule prevents it). If it does, no load happens and Mismatch is set.
- Mismatch is set on any edge where Busy != (cnt != 0), sampled before the update. It stays set until reset.
- StallCount increments on each edge where Stall=1, not counting reset edges. It wraps 0xFFFFFFFF to 0.
- Access-class ops never load cnt. They reach E only when cnt==0, so MDU state is current when they execute.
- Stall_other alone does not block MD ops. It only bubbles E for that cycle. D must then re-present its op (the upstream register holds).

## Timing

- Reset values: E_MDUControl=0, E_Start=0, E_HiLoSel=00, cnt=0, Mismatch=0, StallCount=0. Stall=0 in the cycle after the reset edge (E empty, cnt 0), provided Busy=0.
- Issue: the op sits in E for exactly one cycle. The MDU samples it on the following edge (the issue edge).
- After the issue edge, cnt and Busy are both high for LAT cycles. The edge that takes cnt from 1 to 0 is the edge where the MDU writes HI/LO.
- mult followed directly by an MD op: Stall is high for 1 cycle (E_Start) plus MULT_LAT cycles = 6 cycles. Div-class: 11 cycles.
- An MD op in D with E empty and cnt==0: no stall; it enters E on the next edge.
- Reset mid-operation: cnt clears on the reset edge and MDU Busy clears on the same edge. No Mismatch is raised on that edge.
- E_HiLoSel is valid only in the cycle the op is in E. Read-data muxing uses the MDU HI/LO at that time.

## Test plan

- Reset, then idle with D_MDOp=0 → all outputs 0; StallCount stays 0 for 20 cycles.
- mult in D, then nops → E_MDUControl=1 and E_Start=1 for 1 cycle; cnt reads 5,4,3,2,1 over the next 5 cycles; Stall never high; Mismatch=0.
- mult (3×4) then mflo back-to-back → Stall high for exactly 6 cycles, then StallCount=6; mflo in E shows E_HiLoSel=10 with MDU LO=12.
- divu (7/2) then mthi back-to-back → Stall high for 11 cycles; mthi reaches E only after cnt==0; E_HiLoSel=00; HI=1 before mthi executes.
- Stall_other pulsed while mfhi is in D → E gets a bubble (E_MDUControl=0); next cycle E_MDUControl=5, E_HiLoSel=01; Stall stays 0.
- Reset asserted when cnt=3 → cnt=0 and Stall=0 next cycle; Mismatch=0. Separately, force Busy=0 while cnt=3 → Mismatch=1 and stays 1 until reset.
